// File: rtl/reg_bank8_feeder_pkg.sv
// Shared definitions for the eight-entry register bank feeding the 8-to-1
// datapath select mux and for its clear-sequence controller.
package reg_bank8_feeder_pkg;

    // Bank geometry
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    // Controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Register / mux input indices, A..H
    localparam logic [IDX_W-1:0] IDX_A = 3'd0;
    localparam logic [IDX_W-1:0] IDX_B = 3'd1;
    localparam logic [IDX_W-1:0] IDX_C = 3'd2;
    localparam logic [IDX_W-1:0] IDX_D = 3'd3;
    localparam logic [IDX_W-1:0] IDX_E = 3'd4;
    localparam logic [IDX_W-1:0] IDX_F = 3'd5;
    localparam logic [IDX_W-1:0] IDX_G = 3'd6;
    localparam logic [IDX_W-1:0] IDX_H = 3'd7;

    // Index of the last register visited by the clear sequence
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_H;

    // One-hot strobe for a register index
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/reg_bank8_clr_seq.sv
// Clear-all sequencer: walks a 3-bit counter over the bank, raising one
// clear strobe per cycle, and pulses clr_done once after the last entry.
module reg_bank8_clr_seq
    import reg_bank8_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [NUM_REGS-1:0] clr_stb,
    output state_t              state_dbg
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State, counter and done-pulse registers; reset aborts any sequence
    // without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter advance and clear strobe decode.
    // clr_req is only looked at in IDLE; a request during CLEAR is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clr_stb = '0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clr_stb = idx_onehot(cnt_q);
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == IDX_LAST) begin
                    // Leave before the counter wrap is ever used
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_busy  = (state_q == CLEAR);
    assign clr_done  = done_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/reg_bank8_feeder.sv
// Eight-entry register bank driving all entries in parallel onto the
// 8-to-1 select mux inputs, plus the registered mux select pointer.
//
// Write handshake: wr_ready is high exactly when the controller is IDLE and
// rst is low, independent of wr_valid. A write transfers on a rising edge
// with wr_valid && wr_ready; the source keeps wr_valid/wr_addr/wr_data
// stable until that edge. Valid while not ready has no effect.
module reg_bank8_feeder
    import reg_bank8_feeder_pkg::*;
#(
    parameter int              SIZE      = 16,
    parameter logic [SIZE-1:0] CLR_VALUE = {SIZE{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [SIZE-1:0]  wr_data,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done,
    input  logic             sel_load,
    input  logic [IDX_W-1:0] sel_in,
    output logic [IDX_W-1:0] sel_out,
    output logic [SIZE-1:0]  q_a,
    output logic [SIZE-1:0]  q_b,
    output logic [SIZE-1:0]  q_c,
    output logic [SIZE-1:0]  q_d,
    output logic [SIZE-1:0]  q_e,
    output logic [SIZE-1:0]  q_f,
    output logic [SIZE-1:0]  q_g,
    output logic [SIZE-1:0]  q_h
);

    logic [SIZE-1:0]     bank_q [NUM_REGS];
    logic [NUM_REGS-1:0] clr_stb;
    logic [NUM_REGS-1:0] wr_stb;
    logic                wr_fire;
    state_t              state;

    reg_bank8_clr_seq u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_stb   (clr_stb),
        .state_dbg (state)
    );

    assign wr_ready = (state == IDLE) && !rst;
    assign wr_fire  = wr_valid && wr_ready;

    // Write address decode into a per-entry strobe.
    always_comb begin
        wr_stb = '0;
        if (wr_fire) begin
            wr_stb = idx_onehot(wr_addr);
        end
    end

    // Storage: clear strobes and write strobes never coincide because
    // writes are only accepted in IDLE and clears only happen in CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_stb[i]) begin
                    bank_q[i] <= CLR_VALUE;
                end else if (wr_stb[i]) begin
                    bank_q[i] <= wr_data;
                end
            end
        end
    end

    // Mux select pointer: loads on request regardless of controller state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_out <= '0;
        end else if (sel_load) begin
            sel_out <= sel_in;
        end
    end

    assign q_a = bank_q[IDX_A];
    assign q_b = bank_q[IDX_B];
    assign q_c = bank_q[IDX_C];
    assign q_d = bank_q[IDX_D];
    assign q_e = bank_q[IDX_E];
    assign q_f = bank_q[IDX_F];
    assign q_g = bank_q[IDX_G];
    assign q_h = bank_q[IDX_H];

endmodule

// File: tb/tb_reg_bank8_feeder.sv
// Directed bench for reg_bank8_feeder.
module tb_reg_bank8_feeder;

    localparam int SIZE = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [2:0]      wr_addr  = '0;
    logic [SIZE-1:0] wr_data  = '0;
    logic            clr_req  = 1'b0;
    logic            clr_busy;
    logic            clr_done;
    logic            sel_load = 1'b0;
    logic [2:0]      sel_in   = '0;
    logic [2:0]      sel_out;
    logic [SIZE-1:0] q_a, q_b, q_c, q_d, q_e, q_f, q_g, q_h;

    reg_bank8_feeder #(.SIZE(SIZE), .CLR_VALUE(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .sel_load(sel_load), .sel_in(sel_in), .sel_out(sel_out),
        .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_d(q_d),
        .q_e(q_e), .q_f(q_f), .q_g(q_g), .q_h(q_h)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [SIZE-1:0] exp_bank [8];
    logic [SIZE-1:0] exp_q[$];

    function automatic logic [SIZE-1:0] get_q(input int i);
        case (i)
            0: return q_a;
            1: return q_b;
            2: return q_c;
            3: return q_d;
            4: return q_e;
            5: return q_f;
            6: return q_g;
            default: return q_h;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_q%0d", tag, i), 32'(get_q(i)), 32'(exp_bank[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [SIZE-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int dones;
        int waited;

        // Reset then idle: asynchronous assertion mid-cycle
        step();
        step();
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_bank[i] = '0;
        chk_bank("rst_async");
        chk("rst_sel", 32'(sel_out), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(wr_ready), 32'd1);
        chk("post_rst_busy", 32'(clr_busy), 32'd0);

        // Writes to all registers, back to back
        for (int i = 0; i < 8; i++) begin
            logic [SIZE-1:0] d;
            d = SIZE'(16'h1111 * (i + 1));
            drive_write(3'(i), d);
            chk($sformatf("wr%0d_ready", i), 32'(wr_ready), 32'd1);
            step();
            exp_bank[i] = d;
        end
        wr_valid = 1'b0;
        chk_bank("wr_all");
        sel_load = 1'b1;
        sel_in   = 3'd5;
        step();
        sel_load = 1'b0;
        sel_in   = 3'd2;
        chk("sel_load5", 32'(sel_out), 32'd5);
        step();
        chk("sel_hold", 32'(sel_out), 32'd5);

        // Clear sequence with the bank full
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("clr_busy%0d", k), 32'(clr_busy), 32'd1);
            chk($sformatf("clr_ready%0d", k), 32'(wr_ready), 32'd0);
            if (clr_done) dones++;
            step();
            exp_bank[k] = '0;
            chk_bank($sformatf("clr_step%0d", k));
        end
        chk("clr_end_busy", 32'(clr_busy), 32'd0);
        chk("clr_end_done", 32'(clr_done), 32'd1);
        chk("clr_end_ready", 32'(wr_ready), 32'd1);
        dones++;
        step();
        chk("clr_done_once", 32'(clr_done), 32'd0);
        chk("clr_done_count", 32'(dones), 32'd1);

        // Simultaneous write and clear; reg 3 is cleared on the 4th edge after
        drive_write(3'd3, 16'hBEEF);
        clr_req = 1'b1;
        step();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h0000);
        for (int k = 0; k < 5; k++) begin
            logic [SIZE-1:0] e;
            e = exp_q.pop_front();
            chk($sformatf("sim_qd%0d", k), 32'(q_d), 32'(e));
            if (k == 3) drive_write(3'd6, 16'hCAFE);   // stalled write
            if (k < 4) step();
        end
        // Edges so far in CLEAR: 4. Remaining 4 edges; write must stay stalled.
        for (int k = 4; k < 8; k++) begin
            chk($sformatf("stall_ready%0d", k), 32'(wr_ready), 32'd0);
            step();
            chk($sformatf("stall_qg%0d", k), 32'(q_g), 32'd0);
        end
        chk("stall_idle_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        chk("stall_accept_qg", 32'(q_g), 32'hCAFE);
        exp_bank[6] = 16'hCAFE;

        // Reset mid-clear at index 4
        drive_write(3'd5, 16'h5555);
        step();
        wr_valid = 1'b0;
        exp_bank[5] = 16'h5555;
        chk_bank("pre_abort");
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("abort_qf_live", 32'(q_f), 32'h5555);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_bank[i] = '0;
        chk_bank("abort");
        chk("abort_busy", 32'(clr_busy), 32'd0);
        chk("abort_done", 32'(clr_done), 32'd0);
        step();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (clr_done || clr_busy) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        drive_write(3'd7, 16'h7777);
        chk("abort_wr_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        chk("abort_wr_qh", 32'(q_h), 32'h7777);

        // Held clr_req: two back-to-back sequences, one IDLE cycle between
        clr_req = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            logic idle_exp;
            step();
            idle_exp = (k == 8) || (k == 17);
            chk($sformatf("held_busy%0d", k), 32'(clr_busy), 32'(!idle_exp));
            chk($sformatf("held_done%0d", k), 32'(clr_done), 32'(idle_exp));
            chk($sformatf("held_ready%0d", k), 32'(wr_ready), 32'(idle_exp));
            if (clr_done) dones++;
        end
        chk("held_done_count", 32'(dones), 32'd2);
        clr_req = 1'b0;
        waited = 0;
        while (clr_busy && waited < 20) begin
            step();
            waited++;
        end
        chk("held_drain", 32'(clr_busy), 32'd0);
        chk("held_final_qh", 32'(q_h), 32'd0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
